// File: rtl/button_event_queue_if.sv
// ----------------------------------------------------------------------------
// button_event_queue_if
//   Data-memory side bus of the button event queue.
//   master : processor / dmem mux side (drives address, strobes, write data)
//   slave  : button_event_queue (returns read data and address hit)
// Signals
//   addr      12  dmem word address
//   rd_en      1  one-cycle strobe, processor lw commits this cycle
//   wren       1  dmem write enable
//   data_in   32  dmem write data
//   data_out  32  combinational read data, 0 when hit=0
//   hit        1  addr falls inside the 3-word register window
// ----------------------------------------------------------------------------
interface button_event_queue_if;
    logic [11:0] addr;
    logic        rd_en;
    logic        wren;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        hit;

    modport master (
        output addr,
        output rd_en,
        output wren,
        output data_in,
        input  data_out,
        input  hit
    );

    modport slave (
        input  addr,
        input  rd_en,
        input  wren,
        input  data_in,
        output data_out,
        output hit
    );
endinterface

// File: rtl/button_event_queue.sv
// ----------------------------------------------------------------------------
// button_event_queue
//   Memory-mapped button controller. Each of N_BUTTONS raw inputs passes a
//   2-flop synchroniser and a hold-time debouncer. Debounced presses (and
//   releases when RELEASE_EVENTS=1) are time-stamped and queued in a
//   DEPTH-entry FIFO that the processor drains by reading EVENT.
//
//   Register window (word addresses):
//     BASE_ADDR+0  EVENT   read head entry (0 if empty), pops on rd_en
//     BASE_ADDR+1  STATUS  [31]=overflow [23:16]=count [15:0]=debounced levels
//     BASE_ADDR+2  CONTROL write bit0=flush FIFO+pending, bit1=clear overflow
//
// Ports
//   clock    in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   buttons  in   raw asynchronous button levels, 1 = pressed
//   bus      slave side of button_event_queue_if (addr/rd_en/wren/data_in,
//            data_out/hit)
//   irq      out  registered FIFO non-empty flag
// ----------------------------------------------------------------------------
module button_event_queue #(
    parameter int          N_BUTTONS       = 4,
    parameter int          DEPTH           = 8,
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          TICK_CYCLES     = 50000,
    parameter bit          RELEASE_EVENTS  = 1'b0,
    parameter logic [11:0] BASE_ADDR       = 12'd7
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] buttons,
    button_event_queue_if.slave  bus,
    output logic                 irq
);

    localparam int CW  = (N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1;
    localparam int AW  = $clog2(DEPTH);
    localparam int DW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    // ---------------- state ----------------
    logic [N_BUTTONS-1:0] sync1_q, sync2_q;
    logic [N_BUTTONS-1:0] lvl_q,   lvl_d;
    logic [DW-1:0]        cnt_q   [N_BUTTONS];
    logic [DW-1:0]        cnt_d   [N_BUTTONS];
    logic [N_BUTTONS-1:0] pend_q,  pend_d;
    logic [15:0]          stamp_q [N_BUTTONS];
    logic [15:0]          stamp_d [N_BUTTONS];
    logic [N_BUTTONS-1:0] rel_q,   rel_d;
    logic [TW-1:0]        div_q,   div_d;
    logic [15:0]          ts_q,    ts_d;
    logic [31:0]          mem_q   [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q,  count_d;
    logic                 ovf_q,    ovf_d;
    logic                 irq_q,    irq_d;

    // ---------------- combinational helpers ----------------
    logic [N_BUTTONS-1:0] commit;
    logic                 push_req;
    logic [CW-1:0]        push_idx;
    logic [31:0]          push_word;
    logic                 wr_en;
    logic                 pop;
    logic                 empty;
    logic                 full;
    logic                 flush;
    logic                 clr_ovf;
    logic [11:0]          offset;
    logic [31:0]          event_rd;
    logic [31:0]          status_rd;
    logic                 unused_data_in;

    assign unused_data_in = ^bus.data_in[31:2];

    // Window decode: wrap-safe offset from BASE_ADDR.
    assign offset  = bus.addr - BASE_ADDR;
    assign bus.hit = (offset < 12'd3);

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign pop     = bus.rd_en && (offset == 12'd0) && !empty;
    assign flush   = bus.wren && (offset == 12'd2) && bus.data_in[0];
    assign clr_ovf = bus.wren && (offset == 12'd2) && bus.data_in[1];

    assign event_rd  = empty ? 32'd0 : mem_q[rd_ptr_q];
    assign status_rd = {ovf_q, 7'd0, 8'(count_q), 16'(lvl_q)};

    always_comb begin
        bus.data_out = 32'd0;
        if (bus.hit) begin
            case (offset)
                12'd0:   bus.data_out = event_rd;
                12'd1:   bus.data_out = status_rd;
                default: bus.data_out = 32'd0;
            endcase
        end
    end

    assign irq = irq_q;

    // ---------------- debouncer ----------------
    // Counter runs only while the synced level disagrees with the committed
    // level; any agreement (bounce) restarts the hold window from zero.
    always_comb begin
        lvl_d  = lvl_q;
        commit = '0;
        for (int i = 0; i < N_BUTTONS; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != lvl_q[i]) begin
                if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    lvl_d[i]  = sync2_q[i];
                    commit[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // ---------------- timestamp ----------------
    always_comb begin
        div_d = div_q + 1'b1;
        ts_d  = ts_q;
        if (div_q == TW'(TICK_CYCLES - 1)) begin
            div_d = '0;
            ts_d  = ts_q + 16'd1;
        end
    end

    // ---------------- arbiter ----------------
    // Scan high to low so the lowest pending index wins.
    always_comb begin
        push_req = 1'b0;
        push_idx = '0;
        for (int i = N_BUTTONS - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                push_req = 1'b1;
                push_idx = CW'(i);
            end
        end
    end

    assign push_word = {1'b1, rel_q[push_idx], 6'd0, stamp_q[push_idx], 8'(push_idx)};

    // Pending bits: clear on push, then a fresh commit on the same channel
    // re-arms it (its stamp overwrites whatever was waiting). Flush wins.
    always_comb begin
        pend_d  = pend_q;
        stamp_d = stamp_q;
        rel_d   = rel_q;
        if (push_req) begin
            pend_d[push_idx] = 1'b0;
        end
        for (int i = 0; i < N_BUTTONS; i++) begin
            if (commit[i] && (lvl_d[i] || RELEASE_EVENTS)) begin
                pend_d[i]  = 1'b1;
                stamp_d[i] = ts_q;
                rel_d[i]   = ~lvl_d[i];
            end
        end
        if (flush) begin
            pend_d = '0;
        end
    end

    // ---------------- FIFO control ----------------
    // A full FIFO still accepts a push when a pop frees the head slot.
    assign wr_en = push_req && !flush && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (wr_en && !pop) begin
                count_d = count_q + 1'b1;
            end else if (!wr_en && pop) begin
                count_d = count_q - 1'b1;
            end
            // Dropped event: sticky overflow, takes priority over a clear.
            if (push_req && full && !pop) begin
                ovf_d = 1'b1;
            end
        end
        irq_d = !empty;
    end

    // ---------------- control registers ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            lvl_q    <= '0;
            pend_q   <= '0;
            div_q    <= '0;
            ts_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
            for (int i = 0; i < N_BUTTONS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= buttons;
            sync2_q  <= sync1_q;
            lvl_q    <= lvl_d;
            pend_q   <= pend_d;
            div_q    <= div_d;
            ts_q     <= ts_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_d;
            for (int i = 0; i < N_BUTTONS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // ---------------- data registers (no reset) ----------------
    always_ff @(posedge clock) begin
        rel_q <= rel_d;
        for (int i = 0; i < N_BUTTONS; i++) begin
            stamp_q[i] <= stamp_d[i];
        end
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

endmodule
